// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronizes ps2_clk/ps2_data, deframes 11-bit frames and queues scan codes in a small FIFO.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_keyboard #(
  parameter int unsigned FIFO_AW     = 3,
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow
);

  localparam int unsigned DEPTH  = 1 << FIFO_AW;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BUF_W  = 9;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [1:0]             r_data_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic [BUF_W-1:0]       r_buf;
`ifdef PS2_PARITY_CHECK_EN
  logic                   r_par;
`endif
  logic [7:0]             r_fifo [DEPTH];
  logic [FIFO_AW-1:0]     r_wptr;
  logic [FIFO_AW-1:0]     r_rptr;
  logic                   r_ready;
  logic                   r_overflow;

  logic                   w_fall;
  logic                   w_bit;
  logic                   w_stop;
  logic                   w_frame_ok;
  logic                   w_full;
  logic                   w_push;
  logic                   w_pop;
  logic [FIFO_AW-1:0]     w_wptr_inc;
  logic [FIFO_AW-1:0]     w_rptr_inc;

  // Oldest stage is the MSB; a 1 followed by a 0 marks a falling ps2_clk edge.
  assign w_fall = r_clk_sync[SYNC_STAGES-1] & ~r_clk_sync[SYNC_STAGES-2];
  assign w_bit  = r_data_sync[1];
  assign w_stop = w_fall && (r_cnt == CNT_W'(10));

`ifdef PS2_PARITY_CHECK_EN
  assign w_frame_ok = ~r_buf[0] & w_bit & (^{r_par, r_buf[8:1]});
`else
  assign w_frame_ok = ~r_buf[0] & w_bit;
`endif

  assign w_wptr_inc = r_wptr + FIFO_AW'(1);
  assign w_rptr_inc = r_rptr + FIFO_AW'(1);
  assign w_full     = (w_wptr_inc == r_rptr);
  assign w_push     = w_stop && w_frame_ok && !w_full;
  assign w_pop      = r_ready && !nextdata_n;

  // Input synchronizers.
  always_ff @(posedge clk) begin
    if (clrn) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_data_sync <= {r_data_sync[0], ps2_data};
    end
  end

  // Frame deframer: start and data bits land in r_buf, stop bit is checked live.
  always_ff @(posedge clk) begin
    if (clrn) begin
      r_cnt <= '0;
    end else if (w_fall) begin
      if (r_cnt == CNT_W'(10)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_cnt < CNT_W'(BUF_W)) r_buf[r_cnt] <= w_bit;
`ifdef PS2_PARITY_CHECK_EN
        if (r_cnt == CNT_W'(9)) r_par <= w_bit;
`endif
      end
    end
  end

  // FIFO storage is intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= r_buf[8:1];
  end

  always_ff @(posedge clk) begin
    if (clrn) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_ready    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= w_wptr_inc;
      if (w_pop)  r_rptr <= w_rptr_inc;
      if (w_stop && w_frame_ok && w_full) r_overflow <= 1'b1;
      if (w_push)     r_ready <= 1'b1;
      else if (w_pop) r_ready <= (w_rptr_inc != r_wptr);
    end
  end

  assign data     = r_fifo[r_rptr];
  assign ready    = r_ready;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: table of single-frame vectors plus hand-written multi-frame sequences.
module tb_ps2_keyboard;

  logic       clk;
  logic       clrn;
  logic       ps2_clk;
  logic       ps2_data;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  ps2_keyboard dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

`ifdef PS2_PARITY_CHECK_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] code;
    logic       bad_start;
    logic       bad_par;
    logic       bad_stop;
    logic       exp_ready;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    wait_clks(4);
    ps2_clk = 1'b0;
    wait_clks(8);
    ps2_clk = 1'b1;
    wait_clks(4);
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_start,
                            input logic bad_par, input logic bad_stop);
    logic par;
    par = ~(^code) ^ bad_par;
    send_bit(bad_start);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit(par);
    send_bit(~bad_stop);
  endtask

  task automatic pop_one();
    @(negedge clk);
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C};
    vecs[1] = '{8'h1C, 1'b0, 1'b1, 1'b0, ~PAR_EN, 8'h1C};
    vecs[2] = '{8'h29, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[3] = '{8'h29, 1'b0, 1'b0, 1'b0, 1'b1, 8'h29};
    vecs[4] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
    vecs[6] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF};
    vecs[7] = '{8'hAA, 1'b0, 1'b1, 1'b0, ~PAR_EN, 8'hAA};
    vecs[8] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55};

    clrn = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1;
    wait_clks(3);
    clrn = 1'b0;
    wait_clks(2);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);

    // Pop request on an empty FIFO must not move the read pointer.
    pop_one();
    check("empty_pop_ready", 32'(ready), 32'd0);

    for (int i = 0; i < 9; i++) begin
      send_frame(vecs[i].code, vecs[i].bad_start, vecs[i].bad_par, vecs[i].bad_stop);
      check($sformatf("vec%0d_ready", i), 32'(ready), 32'(vecs[i].exp_ready));
      if (vecs[i].exp_ready) begin
        check($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].exp_data));
        pop_one();
        check($sformatf("vec%0d_ready_after_pop", i), 32'(ready), 32'd0);
      end
      check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'd0);
    end

    // Two frames queued, then popped in order.
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    check("two_head", 32'(data), 32'hF0);
    pop_one();
    check("two_second", 32'(data), 32'h1C);
    check("two_ready", 32'(ready), 32'd1);
    pop_one();
    check("two_empty", 32'(ready), 32'd0);

    // Fill past capacity (7 entries), then drain with nextdata_n held low.
    for (int i = 1; i <= 7; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
    check("fill7_overflow", 32'(overflow), 32'd0);
    send_frame(8'h08, 1'b0, 1'b0, 1'b0);
    check("fill8_overflow", 32'(overflow), 32'd1);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      check($sformatf("drain%0d_ready", i), 32'(ready), 32'd1);
      check($sformatf("drain%0d_data", i), 32'(data), 32'(i));
      nextdata_n = 1'b0;
    end
    @(negedge clk);
    nextdata_n = 1'b1;
    check("drain_empty", 32'(ready), 32'd0);
    check("drain_overflow_sticky", 32'(overflow), 32'd1);

    // Reset in the middle of a frame, then a clean frame.
    send_frame(8'h33, 1'b0, 1'b0, 1'b0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    clrn = 1'b0;
    check("midreset_ready", 32'(ready), 32'd0);
    check("midreset_overflow", 32'(overflow), 32'd0);
    send_frame(8'h45, 1'b0, 1'b0, 1'b0);
    check("after_reset_ready", 32'(ready), 32'd1);
    check("after_reset_data", 32'(data), 32'h45);
    check("after_reset_overflow", 32'(overflow), 32'd0);
    pop_one();
    check("after_reset_empty", 32'(ready), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
